// File: rtl/control_mult.sv
// Moore control FSM for a shift-and-add multiplier: loads the operands,
// alternates conditional accumulate and shift, then holds DONE for DONE_CYCLES.
module control_mult #(
  parameter int WIDTH       = 16,
  parameter int DONE_CYCLES = 4,
  localparam int CW         = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          INIT,
  input  logic          LSB,
  input  logic          Z,
  output logic          RST_DP,
  output logic          ADD,
  output logic          SH,
  output logic          DONE,
  output logic          BUSY,
  output logic [CW-1:0] ITER
);

  localparam int ECW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
  localparam logic [CW-1:0]  ITER_MAX = CW'(WIDTH);
  localparam logic [ECW-1:0] END_LAST = ECW'(DONE_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_DO_ADD   = 3'd3;
  localparam logic [2:0] S_DO_SHIFT = 3'd4;
  localparam logic [2:0] S_FINISH   = 3'd5;

  logic [2:0]     state;
  logic [CW-1:0]  iter;
  logic [ECW-1:0] end_cnt;

  // ITER is cleared as LOAD exits and otherwise holds through FINISH and IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      iter    <= '0;
      end_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (INIT) state <= S_LOAD;
        end
        S_LOAD: begin
          iter    <= '0;
          end_cnt <= '0;
          state   <= S_CHECK;
        end
        S_CHECK: begin
          if (Z || (iter == ITER_MAX)) state <= S_FINISH;
          else if (LSB)                state <= S_DO_ADD;
          else                         state <= S_DO_SHIFT;
        end
        S_DO_ADD: begin
          state <= S_DO_SHIFT;
        end
        S_DO_SHIFT: begin
          if (iter < ITER_MAX) iter <= iter + 1'b1;
          state <= S_CHECK;
        end
        S_FINISH: begin
          if (end_cnt == END_LAST) begin
            end_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            end_cnt <= end_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign RST_DP = (state == S_LOAD);
  assign ADD    = (state == S_DO_ADD);
  assign SH     = (state == S_DO_SHIFT);
  assign DONE   = (state == S_FINISH);
  assign BUSY   = (state != S_IDLE);
  assign ITER   = iter;

endmodule

// File: tb/tb_control_mult.sv
// Self-checking bench for control_mult: a cycle-trace model built from the
// multiplier's iteration rules, directed scenarios and randomized runs.
module tb_control_mult;

  localparam int W  = 16;
  localparam int DC = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          INIT   = 1'b0;
  logic          LSB    = 1'b0;
  logic          Z      = 1'b0;
  logic          RST_DP;
  logic          ADD;
  logic          SH;
  logic          DONE;
  logic          BUSY;
  logic [CW-1:0] ITER;

  int n_cmp = 0;
  int n_bad = 0;

  // mode 0: bench datapath drives LSB/Z from B; 1: Z=0,LSB=1; 2: Z=1
  int           mode    = 0;
  logic [W-1:0] operand = '0;
  logic [W-1:0] b_dp    = '0;
  bit           chk_en  = 1'b0;

  always #5 clk = ~clk;

  control_mult #(.WIDTH(W), .DONE_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .INIT   (INIT),
    .LSB    (LSB),
    .Z      (Z),
    .RST_DP (RST_DP),
    .ADD    (ADD),
    .SH     (SH),
    .DONE   (DONE),
    .BUSY   (BUSY),
    .ITER   (ITER)
  );

  typedef struct packed {
    logic          rst_dp;
    logic          add;
    logic          sh;
    logic          done;
    logic          busy;
    logic          iter_vld;
    logic [CW-1:0] iter;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   last_iter = 0;

  function automatic exp_t mk(logic r, logic a, logic s, logic d, logic bz, logic v, int it);
    exp_t e;
    e.rst_dp   = r;
    e.add      = a;
    e.sh       = s;
    e.done     = d;
    e.busy     = bz;
    e.iter_vld = v;
    e.iter     = CW'(it);
    return e;
  endfunction

  task automatic check_output(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of one whole run, from the shift-add rules.
  function automatic void build_trace();
    int           it = 0;
    logic [W-1:0] b  = operand;
    bit           lsb;
    bit           z;
    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0));
    for (int k = 0; k <= W; k++) begin
      z   = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : (b == '0);
      lsb = (mode == 1) ? 1'b1 : b[0];
      q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, it));
      if (z || it == W) break;
      if (lsb) q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, it));
      q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, it));
      b = b >> 1;
      it++;
    end
    for (int k = 0; k < DC; k++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, it));
    last_iter = it;
  endfunction

  initial begin
    cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        q.delete();
        last_iter = 0;
        cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      end else begin
        if (!cur.busy && INIT) build_trace();
        if (q.size() > 0) cur = q.pop_front();
        else              cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, last_iter);
      end
    end
  end

  // Compare process: every cycle, mid-cycle, against the trace model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check_output("rst_dp", int'(RST_DP), int'(cur.rst_dp));
        check_output("add",    int'(ADD),    int'(cur.add));
        check_output("sh",     int'(SH),     int'(cur.sh));
        check_output("done",   int'(DONE),   int'(cur.done));
        check_output("busy",   int'(BUSY),   int'(cur.busy));
        if (cur.iter_vld) check_output("iter", int'(ITER), int'(cur.iter));
      end
    end
  end

  // Datapath stand-in: B loads on RST_DP and shifts right on SH.
  initial begin
    forever begin
      @(negedge clk);
      if (RST_DP === 1'b1)  b_dp = operand;
      else if (SH === 1'b1) b_dp = b_dp >> 1;
      case (mode)
        1:       begin LSB = 1'b1; Z = 1'b0; end
        2:       begin LSB = 1'b0; Z = 1'b1; end
        default: begin LSB = b_dp[0]; Z = (b_dp == '0); end
      endcase
    end
  end

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while (BUSY !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(name, int'(BUSY === 1'b0), 1);
  endtask

  task automatic apply_stimulus(string name, int m, logic [W-1:0] op, bit poke_sh,
                                int exp_add, int exp_sh, int exp_iter, int exp_lat);
    int adds  = 0;
    int shs   = 0;
    int dones = 0;
    int lat   = -1;
    int c     = 0;
    bit poked = 1'b0;
    @(negedge clk);
    mode    = m;
    operand = op;
    INIT    = 1'b1;
    while (c < 200) begin
      @(negedge clk);
      c++;
      INIT = 1'b0;
      if (poke_sh && !poked && SH === 1'b1) begin
        INIT  = 1'b1;
        poked = 1'b1;
      end
      adds += int'(ADD);
      shs  += int'(SH);
      if (DONE === 1'b1) begin
        dones++;
        if (lat < 0) lat = c - 1;
      end
      if (BUSY !== 1'b1) break;
    end
    INIT = 1'b0;
    check_output({name, "_ended"},   int'(BUSY === 1'b0), 1);
    check_output({name, "_adds"},    adds, exp_add);
    check_output({name, "_shifts"},  shs, exp_sh);
    check_output({name, "_iter"},    int'(ITER), exp_iter);
    check_output({name, "_latency"}, lat, exp_lat);
    check_output({name, "_done_len"}, dones, 4);
  endtask

  initial begin
    bit found;
    bit prev;
    int hold;
    int poke_at;
    bit poke;
    int c;
    int sel;

    #2 reset = 1'b0;
    #1;
    check_output("reset_busy",   int'(BUSY), 0);
    check_output("reset_rst_dp", int'(RST_DP), 0);
    check_output("reset_done",   int'(DONE), 0);
    check_output("reset_iter",   int'(ITER), 0);
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check_output("post_reset_idle", int'(BUSY), 0);

    apply_stimulus("early", 2, W'(0), 1'b0, 0, 0, 0, 2);
    apply_stimulus("b5",    0, W'(5), 1'b0, 2, 3, 3, 10);
    apply_stimulus("full",  1, W'(0), 1'b0, 16, 16, 16, 50);
    apply_stimulus("b5_poke", 0, W'(5), 1'b1, 2, 3, 3, 10);
    repeat (3) @(negedge clk);
    check_output("poke_not_queued", int'(BUSY), 0);

    // Held INIT: a fresh LOAD must follow one idle cycle after DONE drops.
    found = 1'b0;
    prev  = 1'b0;
    @(negedge clk);
    mode    = 0;
    operand = W'(3);
    INIT    = 1'b1;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (prev && DONE === 1'b0) begin
        found = 1'b1;
        check_output("held_idle_after_done", int'(BUSY), 0);
        check_output("held_no_rst_yet", int'(RST_DP), 0);
        @(negedge clk);
        check_output("held_rst_dp_next", int'(RST_DP), 1);
      end
      prev = (DONE === 1'b1);
    end
    INIT = 1'b0;
    check_output("held_done_fall_seen", int'(found), 1);
    wait_idle("held_second_run_ended", 200);

    // Asynchronous reset while in DO_ADD with a nonzero ITER.
    found = 1'b0;
    @(negedge clk);
    mode = 1;
    INIT = 1'b1;
    @(negedge clk);
    INIT = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (ADD === 1'b1 && int'(ITER) >= 3) found = 1'b1;
    end
    check_output("midrun_add_seen", int'(found), 1);
    #2 reset = 1'b0;
    #1;
    check_output("async_rst_dp", int'(RST_DP), 0);
    check_output("async_add",    int'(ADD), 0);
    check_output("async_sh",     int'(SH), 0);
    check_output("async_done",   int'(DONE), 0);
    check_output("async_busy",   int'(BUSY), 0);
    check_output("async_iter",   int'(ITER), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_output("after_async_idle", int'(BUSY), 0);
    check_output("after_async_iter", int'(ITER), 0);

    for (int r = 0; r < 60; r++) begin
      sel     = $urandom_range(0, 9);
      hold    = $urandom_range(1, 3);
      poke    = $urandom_range(0, 1) == 1;
      poke_at = $urandom_range(3, 5);
      @(negedge clk);
      mode    = (sel == 0) ? 2 : (sel == 1) ? 1 : 0;
      operand = (sel >= 7) ? W'($urandom_range(0, 15)) : W'($urandom);
      INIT    = 1'b1;
      c       = 0;
      while (c < 200) begin
        @(negedge clk);
        c++;
        INIT = (c < hold) || (poke && c == poke_at);
        if (BUSY !== 1'b1) break;
      end
      INIT = 1'b0;
      check_output("rand_run_ended", int'(BUSY === 1'b0), 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_mult.md
CONTROL_MULT -- requirements
Module: control_mult

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 16, giving the operand width and the maximum number of shift iterations.
REQ-002 The block SHALL provide parameter DONE_CYCLES, default 4, giving the number of cycles DONE stays high.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset: 0 resets immediately, independent of clk.
REQ-005 The block SHALL have port INIT, input, 1 bit, the start request, level-sampled in IDLE.
REQ-006 The block SHALL have port LSB, input, 1 bit, bit 0 of the datapath multiplier register B.
REQ-007 The block SHALL have port Z, input, 1 bit, high when the datapath multiplier register B equals zero.
REQ-008 The block SHALL have port RST_DP, output, 1 bit, which loads the operands and clears the accumulator in the datapath.
REQ-009 The block SHALL have port ADD, output, 1 bit, the accumulator add enable (acc <= acc + A).
REQ-010 The block SHALL have port SH, output, 1 bit, the shift enable (A left by 1, B right by 1).
REQ-011 The block SHALL have port DONE, output, 1 bit, indicating that the result is valid.
REQ-012 The block SHALL have port BUSY, output, 1 bit, high in every state except IDLE.
REQ-013 The block SHALL have port ITER, output, CW = ceil(log2(WIDTH+1)) bits, the count of completed shifts.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, LOAD, CHECK, DO_ADD, DO_SHIFT and FINISH, held in one state register.
REQ-015 All outputs SHALL decode from registered state and counters only, with no combinational path from any input (Moore).
REQ-016 IDLE SHALL drive all outputs 0 and go to LOAD when INIT=1; otherwise it stays in IDLE.
REQ-017 LOAD SHALL assert RST_DP for exactly 1 cycle, clear ITER to 0, and go to CHECK.
REQ-018 CHECK SHALL assert no strobe and choose the next state in priority order: (Z=1 or ITER==WIDTH) -> FINISH; else LSB=1 -> DO_ADD; else -> DO_SHIFT.
REQ-019 DO_ADD SHALL assert ADD for exactly 1 cycle and go to DO_SHIFT.
REQ-020 DO_SHIFT SHALL assert SH for exactly 1 cycle, increment ITER on the exit edge, and go to CHECK.
REQ-021 ITER SHALL saturate at WIDTH and never wrap, and SHALL hold its value through FINISH and IDLE until the next LOAD.
REQ-022 FINISH SHALL assert DONE for exactly DONE_CYCLES consecutive cycles using an internal end counter, then go to IDLE.
REQ-023 ADD, SH and RST_DP SHALL be mutually exclusive and SHALL never be high together with DONE.
REQ-024 INIT SHALL be ignored in every state except IDLE; a new start request issued during BUSY=1 is dropped, not queued.
REQ-025 If INIT is still 1 when FINISH exits to IDLE, the block SHALL enter LOAD on the next edge, so a held INIT causes back-to-back runs.
REQ-026 Per iteration, the latency SHALL be 3 cycles when LSB=1 and 2 cycles when LSB=0, plus 1 cycle for the final CHECK.

Reset
REQ-027 When reset=0, the block SHALL immediately force the state to IDLE, ITER and the end counter to 0, and all outputs to 0, regardless of clk and in any state.
REQ-028 After reset is released, the block SHALL take no action until the first rising clk edge that samples INIT=1 in IDLE.

Verification
REQ-029 Early exit: drive Z=1, then pulse INIT -> expect LOAD, one CHECK, DONE high for 4 cycles, then IDLE; ADD and SH never asserted; ITER=0.
REQ-030 Operand B=5 (0b101): the bench models B shifting on SH and drives LSB/Z from it -> expect ADD pulses=2, SH pulses=3, ITER=3, DONE begins 10 cycles after the edge that samples INIT.
REQ-031 Full count: tie Z=0 and LSB=1 -> expect 16 ADD and 16 SH pulses, ITER=16, FINISH entered on cycle 51 after the edge that samples INIT.
REQ-032 Reset mid-operation: drive reset=0 asynchronously while in DO_ADD -> expect all outputs 0 before the next clk edge, state IDLE, ITER=0.
REQ-033 INIT handling: pulse INIT during DO_SHIFT -> expect no effect on the run; hold INIT=1 continuously -> expect RST_DP exactly 1 cycle after DONE falls.
